lock_reset_sequencer: RTL and testbench

//  Consumer of the MMCM LOCKED output. Runs on the free-running board clock, never on an MMCM output.

---
 rtl/lock_seq_pkg.sv | 26 ++
 rtl/sync_ff_chain.sv | 32 +++
 rtl/lock_reset_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lock_reset_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_seq_pkg.sv
// Shared definitions for the clocking-block reset sequencers: FSM encodings and a clog2 helper.
// Latency: none (package only).
// Backpressure: not applicable.
package lock_seq_pkg;

  // Sequencer FSM state encodings
  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_STABLE    = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_MMCM_RST  = 3'd4;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Generic async-reset single-bit synchroniser for slow level signals crossing into clk_i.
// Latency: d_i sampled at edge E appears on q_o after edge E+STAGES-1.
// Backpressure: none; free-running level path.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage deeper every cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser flops, cleared to "not locked" on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lock_reset_sequencer.sv
// Qualifies MMCM LOCKED on the board clock and releases per-domain resets in order; pulses MMCM reset on timeout.
// Latency: rst_n_o[0] rises SYNC_STAGES+LOCK_STABLE_CYCLES edges after locked_i is first sampled high; loss drops resets within SYNC_STAGES+1 edges.
// Backpressure: none; all outputs are registered levels with no handshake.
module lock_reset_sequencer
  import lock_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 16,
  parameter int N_RESETS            = 3,
  parameter int LOCK_TIMEOUT_CYCLES = 80000,
  parameter int MMCM_RST_CYCLES     = 8,
  parameter int CNT_W               = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                locked_i,
  output logic                mmcm_rst_o,
  output logic [N_RESETS-1:0] rst_n_o,
  output logic                ready_o,
  output logic [CNT_W-1:0]    lock_loss_count_o
);

  // One counter is shared by the timeout, stability, stagger and pulse phases,
  // so it is sized for the widest of them.
  localparam int TO_W  = clog2(LOCK_TIMEOUT_CYCLES);
  localparam int STB_W = clog2(LOCK_STABLE_CYCLES + 1);
  localparam int SG_W  = clog2(STAGGER_CYCLES);
  localparam int MR_W  = clog2(MMCM_RST_CYCLES);
  localparam int W_A   = (TO_W > STB_W) ? TO_W : STB_W;
  localparam int W_B   = (SG_W > MR_W) ? SG_W : MR_W;
  localparam int W_AB  = (W_A > W_B) ? W_A : W_B;
  localparam int CTR_W = (W_AB > 1) ? W_AB : 1;

  logic                lock_sync;

  logic [2:0]          state_q, state_d;
  logic [CTR_W-1:0]    cnt_q, cnt_d;
  logic [N_RESETS-1:0] rst_n_q, rst_n_d;
  logic                ready_q, ready_d;
  logic                mmcm_rst_q, mmcm_rst_d;
  logic [CNT_W-1:0]    loss_cnt_q, loss_cnt_d;

  logic                timeout_hit;
  logic                stable_done;
  logic                stagger_done;
  logic                pulse_done;
  logic [N_RESETS-1:0] rst_shift;
  logic                last_release;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (locked_i),
    .q_o     (lock_sync)
  );

  assign timeout_hit  = (cnt_q == CTR_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign stable_done  = (cnt_q == CTR_W'(LOCK_STABLE_CYCLES - 1));
  assign stagger_done = (cnt_q == CTR_W'(STAGGER_CYCLES - 1));
  assign pulse_done   = (cnt_q == CTR_W'(MMCM_RST_CYCLES - 1));
  // Releasing one more bit: shift the released mask up and fill bit 0,
  // so bits can only ever come out of reset in index order.
  assign rst_shift    = (rst_n_q << 1) | N_RESETS'(1);
  assign last_release = &rst_shift;

  // State, shared counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_WAIT_LOCK;
      cnt_q      <= '0;
      rst_n_q    <= '0;
      ready_q    <= 1'b0;
      mmcm_rst_q <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      mmcm_rst_q <= mmcm_rst_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Next state and shared counter; every exit clears the counter for the next phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_MMCM_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (stable_done) begin
          state_d = (N_RESETS == 1) ? ST_RUN : ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (stagger_done) begin
          cnt_d = '0;
          if (last_release) begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_MMCM_RST: begin
        // Lock status is deliberately ignored while the MMCM is being reset
        if (pulse_done) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, aligned with the state transitions above
  always_comb begin
    rst_n_d    = rst_n_q;
    ready_d    = ready_q;
    mmcm_rst_d = 1'b0;
    loss_cnt_d = loss_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_sync && timeout_hit) begin
          mmcm_rst_d = 1'b1;
        end
      end
      ST_STABLE: begin
        if (lock_sync && stable_done) begin
          rst_n_d = N_RESETS'(1);
          ready_d = (N_RESETS == 1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lock_sync) begin
          rst_n_d = '0;
          ready_d = 1'b0;
          if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
          end
        end else if (state_q == ST_RELEASE && stagger_done) begin
          rst_n_d = rst_shift;
          ready_d = last_release;
        end
      end
      ST_MMCM_RST: begin
        mmcm_rst_d = !pulse_done;
      end
      default: begin
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign mmcm_rst_o        = mmcm_rst_q;
  assign rst_n_o           = rst_n_q;
  assign ready_o           = ready_q;
  assign lock_loss_count_o = loss_cnt_q;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Self-checking bench: behavioural phase model plus directed latency checks and randomized lock patterns.
// Latency: model tracks the synchroniser as a plain sample delay line.
// Backpressure: not applicable.
module tb_lock_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 16;
  localparam int STG  = 4;
  localparam int NR   = 3;
  localparam int TO   = 100;
  localparam int MR   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_WAIT = 0;
  localparam int M_LOCK = 1;
  localparam int M_MMCM = 2;

  logic          clk_i    = 1'b0;
  logic          rst_n_i  = 1'b0;
  logic          locked_i = 1'b0;
  logic          mmcm_rst_o;
  logic [NR-1:0] rst_n_o;
  logic          ready_o;
  logic [CW-1:0] lock_loss_count_o;

  lock_reset_sequencer #(
    .SYNC_STAGES         (SYNC),
    .LOCK_STABLE_CYCLES  (LSC),
    .STAGGER_CYCLES      (STG),
    .N_RESETS            (NR),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MMCM_RST_CYCLES     (MR),
    .CNT_W               (CW)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .locked_i          (locked_i),
    .mmcm_rst_o        (mmcm_rst_o),
    .rst_n_o           (rst_n_o),
    .ready_o           (ready_o),
    .lock_loss_count_o (lock_loss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: lock history as a sample delay line and a phase with a time-in-phase count
  bit hist[$];
  int m_mode;
  int m_t;
  int m_r;
  int m_p;
  int m_cnt;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int bits_released();
    int b;
    if (m_mode != M_LOCK || m_r < LSC) return 0;
    b = 1 + (m_r - LSC) / STG;
    return (b > NR) ? NR : b;
  endfunction

  task automatic model_reset();
    hist   = {};
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_mode = M_WAIT;
    m_t    = 0;
    m_r    = 0;
    m_p    = 0;
    m_cnt  = 0;
  endtask

  // One clock edge: advance model with the synchronised lock value, then compare outputs
  task automatic step();
    bit s;
    int b;
    @(posedge clk_i);
    s = hist.pop_front();
    hist.push_back(locked_i);
    case (m_mode)
      M_WAIT: begin
        if (s) begin
          m_mode = M_LOCK; m_r = 0;
        end else if (m_t == TO - 1) begin
          m_mode = M_MMCM; m_p = 0;
        end else begin
          m_t++;
        end
      end
      M_LOCK: begin
        if (!s) begin
          if (bits_released() > 0 && m_cnt < CMAX) m_cnt++;
          m_mode = M_WAIT; m_t = 0;
        end else begin
          m_r++;
        end
      end
      default: begin
        if (m_p == MR - 1) begin
          m_mode = M_WAIT; m_t = 0;
        end else begin
          m_p++;
        end
      end
    endcase
    cyc++;
    #1;
    b = bits_released();
    check_eq("rst_n_o",    int'(rst_n_o), (1 << b) - 1);
    check_eq("ready_o",    int'(ready_o), (b == NR) ? 1 : 0);
    check_eq("mmcm_rst_o", int'(mmcm_rst_o), (m_mode == M_MMCM) ? 1 : 0);
    check_eq("loss_count", int'(lock_loss_count_o), m_cnt);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge
  task automatic do_reset(input string tag);
    #3;
    rst_n_i = 1'b0;
    #1;
    check_eq({tag, "_rst_n_o"},    int'(rst_n_o), 0);
    check_eq({tag, "_ready_o"},    int'(ready_o), 0);
    check_eq({tag, "_mmcm_rst_o"}, int'(mmcm_rst_o), 0);
    check_eq({tag, "_loss_count"}, int'(lock_loss_count_o), 0);
    locked_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Step n cycles recording when each reset bit and ready first rise, relative to base
  task automatic measure(input int base, input int n,
                         output int d0, output int d1, output int d2, output int dr);
    d0 = -1; d1 = -1; d2 = -1; dr = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (d0 < 0 && rst_n_o[0]) d0 = cyc - base;
      if (d1 < 0 && rst_n_o[1]) d1 = cyc - base;
      if (d2 < 0 && rst_n_o[2]) d2 = cyc - base;
      if (dr < 0 && ready_o)    dr = cyc - base;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, d1, d2, dr, l0, dl, r1, r2, f1, w;
    bit prev;

    model_reset();
    do_reset("reset");

    // Lock from cold: ordered release at +18/+22/+26
    locked_i = 1'b1;
    step(); e0 = cyc;
    measure(e0, 40, d0, d1, d2, dr);
    check_eq("t1_rel0", d0, SYNC + LSC);
    check_eq("t1_rel1", d1, SYNC + LSC + STG);
    check_eq("t1_rel2", d2, SYNC + LSC + 2 * STG);
    check_eq("t1_ready", dr, SYNC + LSC + 2 * STG);

    // Loss in RUN, then re-lock
    locked_i = 1'b0;
    step(); l0 = cyc; dl = -1;
    for (int i = 0; i < 6; i++) begin
      if (dl < 0 && rst_n_o == '0 && !ready_o) dl = cyc - l0;
      step();
    end
    check_eq("t3_loss_lat", dl, SYNC);
    check_eq("t3_count", int'(lock_loss_count_o), 1);
    locked_i = 1'b1;
    step(); e0 = cyc;
    measure(e0, 40, d0, d1, d2, dr);
    check_eq("t3_relock0", d0, SYNC + LSC);
    check_eq("t3_relock2", d2, SYNC + LSC + 2 * STG);

    // Glitch during qualification restarts it and is not a loss
    do_reset("t2");
    locked_i = 1'b1;
    repeat (10) step();
    locked_i = 1'b0;
    step();
    locked_i = 1'b1;
    step(); e0 = cyc;
    measure(e0, 40, d0, d1, d2, dr);
    check_eq("t2_rel0", d0, SYNC + LSC);
    check_eq("t2_count", int'(lock_loss_count_o), 0);

    // No lock: periodic MMCM reset pulses
    do_reset("t4");
    e0 = cyc; r1 = -1; r2 = -1; f1 = -1; prev = 1'b0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (!prev && mmcm_rst_o) begin
        if (r1 < 0) r1 = cyc - e0; else if (r2 < 0) r2 = cyc - e0;
      end
      if (prev && !mmcm_rst_o && f1 < 0) f1 = cyc - e0;
      prev = mmcm_rst_o;
    end
    check_eq("t4_first_pulse", r1, TO);
    check_eq("t4_width", f1 - r1, MR);
    check_eq("t4_period", r2 - r1, TO + MR);

    // Lock toggling during the pulse must not change its width
    for (int i = 0; i < 2 * (TO + MR) && !mmcm_rst_o; i++) step();
    w = 0;
    for (int i = 0; i < 3 * MR && mmcm_rst_o; i++) begin
      locked_i = 1'($urandom_range(0, 1));
      w++;
      step();
    end
    check_eq("t5_width", w, MR);
    locked_i = 1'b0;
    repeat (4) step();

    // Reset asserted mid-RELEASE
    do_reset("t5a");
    locked_i = 1'b1;
    step();
    repeat (20) step();
    check_eq("t5_pre_bits", int'(rst_n_o), 1);
    do_reset("t5_midrel");

    // Saturation of the loss counter
    for (int k = 0; k < 5; k++) begin
      locked_i = 1'b1;
      repeat (30) step();
      locked_i = 1'b0;
      repeat (6) step();
    end
    check_eq("t6_saturate", int'(lock_loss_count_o), CMAX);

    // Randomized lock patterns against the model
    do_reset("rand");
    for (int k = 0; k < 12; k++) begin
      locked_i = 1'b1;
      repeat ($urandom_range(1, 45)) step();
      locked_i = 1'b0;
      repeat ($urandom_range(1, 130)) step();
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) locked_i = ~locked_i;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
